// File: rtl/membus_arbiter_pkg.sv
// Shared types and constants for the multi-channel memory bus arbiter.
// Default-width command types describe the standard 32-bit CPU configuration.
package membus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } membus_state_t;

    localparam int MEMBUS_ADDR_W = 32;
    localparam int MEMBUS_DATA_W = 32;

    typedef logic [MEMBUS_DATA_W/8-1:0] mem_be_t;

    typedef struct packed {
        logic                     we;
        mem_be_t                  be;
        logic [MEMBUS_ADDR_W-1:0] addr;
        logic [MEMBUS_DATA_W-1:0] wdata;
    } membus_cmd_t;

    localparam int MEMBUS_CH_DATA = 0;
    localparam int MEMBUS_CH_INST = 1;

endpackage

// File: rtl/membus_arbiter_rr_pick.sv
// Combinational one-hot request picker: searches upward from a start pointer,
// wrapping at NUM_CH. A pointer tied to zero gives lowest-index-wins priority.
module membus_rr_pick #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt_oh
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        gnt_oh = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_CH);
            if (!found && req[idx]) begin
                gnt_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// NUM_CH-channel memory bus arbiter with req/ack handshake, wait states and timeout.
// Define MEMBUS_RR_EN for round-robin arbitration; otherwise lowest channel index wins.
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_we,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_be,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_ack,
    output logic                       ch_err,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       mem_ce,
    output logic                       mem_we,
    output logic [DATA_W/8-1:0]        mem_be,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_ready
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    membus_state_t     state_q, state_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [BE_W-1:0]   be_arr    [NUM_CH];
    logic [ADDR_W-1:0] addr_arr  [NUM_CH];
    logic [DATA_W-1:0] wdata_arr [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign be_arr[gi]    = ch_be[gi*BE_W +: BE_W];
            assign addr_arr[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = ch_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic [IDX_W-1:0]  ptr;
    logic [NUM_CH-1:0] pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

`ifdef MEMBUS_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Pointer moves past the channel being acknowledged so it yields next time.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == RESP) begin
            ptr_d = (int'(win_q) == NUM_CH - 1) ? '0 : win_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    membus_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req    (ch_req),
        .ptr    (ptr),
        .gnt_oh (pick_oh)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (pick_oh[k]) begin
                pick_idx = IDX_W'(k);
            end
        end
    end

    assign pick_any = |pick_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    win_d   = pick_idx;
                    we_d    = ch_we[pick_idx];
                    be_d    = be_arr[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // mem_ready takes precedence over a timeout landing in the same cycle.
                if (mem_ready) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_ack    = '0;
        ch_err    = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            BUSY: begin
                mem_ce    = 1'b1;
                mem_we    = we_q;
                mem_be    = be_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                ch_ack[win_q] = 1'b1;
                ch_err        = err_q;
            end
            default: ;
        endcase
    end

    assign ch_rdata = rdata_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed testbench for membus_arbiter (2 channels, 32-bit, timeout 16).
// Contention expectations follow MEMBUS_RR_EN when it is defined for the build.
module tb_membus_arbiter;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_CH-1:0]          ch_req;
    logic [NUM_CH-1:0]          ch_we;
    logic [NUM_CH*DATA_W/8-1:0] ch_be;
    logic [NUM_CH*ADDR_W-1:0]   ch_addr;
    logic [NUM_CH*DATA_W-1:0]   ch_wdata;
    logic [NUM_CH-1:0]          ch_ack;
    logic                       ch_err;
    logic [DATA_W-1:0]          ch_rdata;
    logic                       mem_ce;
    logic                       mem_we;
    logic [DATA_W/8-1:0]        mem_be;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic [DATA_W-1:0]          mem_rdata;
    logic                       mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    membus_arbiter #(
        .NUM_CH      (NUM_CH),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_req    (ch_req),
        .ch_we     (ch_we),
        .ch_be     (ch_be),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_ack    (ch_ack),
        .ch_err    (ch_err),
        .ch_rdata  (ch_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        ch_we[ch]           = we;
        ch_be[ch*4 +: 4]    = be;
        ch_addr[ch*32 +: 32] = addr;
        ch_wdata[ch*32 +: 32] = wdata;
    endtask

    initial begin
        logic [1:0] exp_ack;

        rst_n     = 1'b0;
        ch_req    = '0;
        ch_we     = '0;
        ch_be     = '0;
        ch_addr   = '0;
        ch_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        check("rst_ack", ch_ack, 2'b00);
        check("rst_ce", mem_ce, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_rdata", ch_rdata, 32'h0);
        check("rst_err", ch_err, 1'b0);
        rst_n = 1'b1;
        tick();
        $display("reset released");

        // Single read on ch0, memory ready in the first BUSY cycle
        set_ch(0, 1'b0, 4'hF, 32'h100, 32'h0);
        ch_req = 2'b01;
        tick();
        check("t1_ce", mem_ce, 1'b1);
        check("t1_addr", mem_addr, 32'h100);
        check("t1_we", mem_we, 1'b0);
        check("t1_ack_early", ch_ack, 2'b00);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        check("t1_ack", ch_ack, 2'b01);
        check("t1_err", ch_err, 1'b0);
        check("t1_rdata", ch_rdata, 32'hDEADBEEF);
        check("t1_ce_resp", mem_ce, 1'b0);
        ch_req    = 2'b00;
        mem_ready = 1'b0;
        tick();
        $display("txn1 read ch0 addr=100 rdata=%h ack seen", ch_rdata);

        // Byte write on ch1 with two wait states
        set_ch(1, 1'b1, 4'b0010, 32'h204, 32'h0000AB00);
        ch_req = 2'b10;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_ce", mem_ce, 1'b1);
            check("t2_we", mem_we, 1'b1);
            check("t2_be", mem_be, 4'b0010);
            check("t2_addr", mem_addr, 32'h204);
            check("t2_wdata", mem_wdata, 32'h0000AB00);
            if (i == 2) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h12345678;
            end
            tick();
        end
        check("t2_ack", ch_ack, 2'b10);
        check("t2_rdata_kept", ch_rdata, 32'hDEADBEEF);
        ch_req    = 2'b00;
        mem_ready = 1'b0;
        tick();
        $display("txn2 write ch1 addr=204 be=0010 done");

        // Contention: both channels hold req, memory always ready
        set_ch(0, 1'b0, 4'hF, 32'h1000, 32'h0);
        set_ch(1, 1'b0, 4'hF, 32'h2000, 32'h0);
        ch_req    = 2'b11;
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADF00D;
        for (int n = 0; n < 6; n++) begin
`ifdef MEMBUS_RR_EN
            exp_ack = (n % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_ack = 2'b01;
`endif
            tick();
            check("t3_ce", mem_ce, 1'b1);
            tick();
            check("t3_ack", ch_ack, exp_ack);
            tick();
            $display("txn3.%0d contention ack=%b", n, exp_ack);
        end
        ch_req    = 2'b00;
        mem_ready = 1'b0;

        // Three wait states, then an immediate back-to-back request
        set_ch(0, 1'b0, 4'hF, 32'h300, 32'h0);
        ch_req = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("t4_ce", mem_ce, 1'b1);
            check("t4_noack", ch_ack, 2'b00);
            if (c == 4) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hCAFEF00D;
            end
        end
        tick();
        check("t4_ack", ch_ack, 2'b01);
        check("t4_rdata", ch_rdata, 32'hCAFEF00D);
        mem_ready = 1'b0;
        tick();
        check("t4_idle_ce", mem_ce, 1'b0);
        tick();
        check("t4_restart_ce", mem_ce, 1'b1);
        mem_ready = 1'b1;
        mem_rdata = 32'h01020304;
        tick();
        check("t4_ack2", ch_ack, 2'b01);
        check("t4_rdata2", ch_rdata, 32'h01020304);
        ch_req    = 2'b00;
        mem_ready = 1'b0;
        tick();
        $display("txn4 wait-state read rdata=%h", ch_rdata);

        // Timeout: memory never answers
        set_ch(1, 1'b0, 4'hF, 32'h400, 32'h0);
        ch_req = 2'b10;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("t5_ce", mem_ce, 1'b1);
            check("t5_noack", ch_ack, 2'b00);
        end
        tick();
        check("t5_ack", ch_ack, 2'b10);
        check("t5_err", ch_err, 1'b1);
        check("t5_rdata_kept", ch_rdata, 32'h01020304);
        check("t5_ce_resp", mem_ce, 1'b0);
        ch_req = 2'b00;
        tick();
        ch_req = 2'b10;
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h11112222;
        tick();
        check("t5_next_ack", ch_ack, 2'b10);
        check("t5_next_err", ch_err, 1'b0);
        check("t5_next_rdata", ch_rdata, 32'h11112222);
        ch_req    = 2'b00;
        mem_ready = 1'b0;
        tick();
        $display("txn5 timeout then normal read rdata=%h", ch_rdata);

        // Reset asserted in the second BUSY cycle of a stalled read
        set_ch(0, 1'b0, 4'hF, 32'h500, 32'h0);
        ch_req = 2'b01;
        tick();
        tick();
        check("t6_busy", mem_ce, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ce", mem_ce, 1'b0);
        check("t6_rst_addr", mem_addr, 32'h0);
        check("t6_rst_ack", ch_ack, 2'b00);
        check("t6_rst_rdata", ch_rdata, 32'h0);
        tick();
        check("t6_rst_ack2", ch_ack, 2'b00);
        rst_n = 1'b1;
        tick();
        check("t6_fresh_ce", mem_ce, 1'b1);
        mem_ready = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        tick();
        check("t6_fresh_ack", ch_ack, 2'b01);
        check("t6_fresh_rdata", ch_rdata, 32'h5A5A5A5A);
        ch_req    = 2'b00;
        mem_ready = 1'b0;
        tick();
        $display("txn6 reset mid-busy then fresh read rdata=%h", ch_rdata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
